// File: rtl/minibyte_pkg.sv
// Shared definitions for the MiniByte CPU: opcodes, ALU op codes, sequencer states
// and the decoded-instruction bundle passed from minibyte_decode to minibyte_ctrl.
package minibyte_pkg;

   localparam logic [7:0] OP_NOP          = 8'h00;
   localparam logic [7:0] OP_LDI          = 8'h01;
   localparam logic [7:0] OP_LDA          = 8'h02;
   localparam logic [7:0] OP_STA          = 8'h03;
   localparam logic [7:0] OP_JMP          = 8'h04;
   localparam logic [7:0] OP_JZ           = 8'h05;
   localparam logic [7:0] OP_JN           = 8'h06;
   localparam logic [7:0] OP_HLT          = 8'h07;
   localparam logic [7:0] OP_ALUI_BASE    = 8'h08;
   localparam logic [7:0] OP_ALUM_BASE    = 8'h10;
   localparam logic [7:0] OP_ILLEGAL_BASE = 8'h18;

   // The ALU opcode is carried directly in IR[2:0] of ALUI/ALUM instructions.
   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_AND   = 3'd2;
   localparam logic [2:0] ALU_OR    = 3'd3;
   localparam logic [2:0] ALU_XOR   = 3'd4;
   localparam logic [2:0] ALU_PASSB = 3'd5;
   localparam logic [2:0] ALU_SHR   = 3'd6;
   localparam logic [2:0] ALU_NOT   = 3'd7;

   typedef enum logic [2:0] {
      FETCH_OP,
      FETCH_ARG,
      READ_MEM,
      EXEC,
      WRITE_MEM,
      HALT
   } state_t;

   typedef struct packed {
      logic needs_mem_rd;
      logic is_store;
      logic is_branch;
      logic is_alu;
      logic is_halt;
      logic is_illegal;
   } decode_t;

endpackage

// File: rtl/minibyte_decode.sv
// Combinational instruction classifier: maps the opcode byte to the control
// attributes the sequencer needs to choose its path after the operand fetch.
module minibyte_decode
   import minibyte_pkg::*;
(
   input  logic [7:0] ir,
   output decode_t    dec
);

   always_comb begin
      dec = '0;
      if (ir >= OP_ILLEGAL_BASE) begin
         dec.is_illegal = 1'b1;
      end else if (ir >= OP_ALUM_BASE) begin
         dec.is_alu       = 1'b1;
         dec.needs_mem_rd = 1'b1;
      end else if (ir >= OP_ALUI_BASE) begin
         dec.is_alu = 1'b1;
      end else begin
         case (ir)
            OP_LDA:               dec.needs_mem_rd = 1'b1;
            OP_STA:               dec.is_store     = 1'b1;
            OP_JMP, OP_JZ, OP_JN: dec.is_branch    = 1'b1;
            OP_HLT:               dec.is_halt      = 1'b1;
            default:              ;
         endcase
      end
   end

endmodule

// File: rtl/minibyte_ctrl.sv
// MiniByte fetch/decode/execute sequencer: fetches 2-byte instructions over a
// req/ack port, holds A/PC/IR/OPR and the Z/N flags, and drives minibyte_alu.
module minibyte_ctrl
   import minibyte_pkg::*;
#(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter int          ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic [2:0]        alu_op,
   input  logic [7:0]        alu_res,
   input  logic              alu_z,
   input  logic              alu_n,
   output logic [7:0]        acc_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic              halted,
   output logic              illegal
);

   localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] opr_addr;
   logic [7:0]        acc;
   logic [7:0]        ir;
   logic [7:0]        opr;
   logic              flag_z;
   logic              flag_n;
   logic              illegal_q;
   logic              req_raw;
   logic              we_raw;
   logic              is_load;
   logic              branch_taken;
   decode_t           dec;

   minibyte_decode u_decode (
      .ir  (ir),
      .dec (dec)
   );

   assign opr_addr     = ADDR_W'(opr);
   assign is_load      = (ir == OP_LDI) || (ir == OP_LDA);
   assign branch_taken = dec.is_branch &&
                         ((ir == OP_JMP) || ((ir == OP_JZ) && flag_z) || ((ir == OP_JN) && flag_n));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH_OP;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_raw   = 1'b0;
      we_raw    = 1'b0;
      mem_addr  = pc;
      unique case (state)
         FETCH_OP: begin
            req_raw = 1'b1;
            if (mem_ack) state_nxt = FETCH_ARG;
         end
         FETCH_ARG: begin
            req_raw = 1'b1;
            if (mem_ack) begin
               if (dec.is_halt || dec.is_illegal) state_nxt = HALT;
               else if (dec.needs_mem_rd)         state_nxt = READ_MEM;
               else if (dec.is_store)             state_nxt = WRITE_MEM;
               else                               state_nxt = EXEC;
            end
         end
         READ_MEM: begin
            req_raw  = 1'b1;
            mem_addr = opr_addr;
            if (mem_ack) state_nxt = EXEC;
         end
         WRITE_MEM: begin
            req_raw  = 1'b1;
            we_raw   = 1'b1;
            mem_addr = opr_addr;
            if (mem_ack) state_nxt = FETCH_OP;
         end
         EXEC:    state_nxt = FETCH_OP;
         HALT:    state_nxt = HALT;
         default: state_nxt = HALT;
      endcase
   end

   // Gating with rst lets an in-flight request vanish in the same cycle reset rises.
   assign mem_req   = req_raw & ~rst;
   assign mem_we    = we_raw & ~rst;
   assign mem_wdata = acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc        <= PC_INIT;
         acc       <= 8'h00;
         ir        <= 8'h00;
         opr       <= 8'h00;
         flag_z    <= 1'b0;
         flag_n    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         case (state)
            FETCH_OP: begin
               if (mem_ack) begin
                  ir <= mem_rdata;
                  pc <= pc + PC_ONE;
               end
            end
            FETCH_ARG: begin
               if (mem_ack) begin
                  opr <= mem_rdata;
                  pc  <= pc + PC_ONE;
                  if (dec.is_illegal) illegal_q <= 1'b1;
               end
            end
            READ_MEM: begin
               if (mem_ack) opr <= mem_rdata;
            end
            EXEC: begin
               if (dec.is_alu) begin
                  acc    <= alu_res;
                  flag_z <= alu_z;
                  flag_n <= alu_n;
               end else if (is_load) begin
                  acc    <= opr;
                  flag_z <= (opr == 8'h00);
                  flag_n <= opr[7];
               end
               if (branch_taken) pc <= opr_addr;
            end
            default: ;
         endcase
      end
   end

   assign alu_a   = acc;
   assign alu_b   = opr;
   assign alu_op  = ir[2:0];
   assign acc_out = acc;
   assign pc_out  = pc;
   assign halted  = (state == HALT);
   assign illegal = illegal_q;

endmodule

// File: tb/tb_minibyte_ctrl.sv
// Self-checking bench for minibyte_ctrl: shared memory model with configurable
// wait states, a behavioural stand-in for minibyte_alu, and an access scoreboard.
`timescale 1ns/1ps
module tb_minibyte_ctrl;
   import minibyte_pkg::*;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } acc_t;

   logic clk = 1'b0;
   logic rst0, rst1, sel;
   int   ack_lat;
   int   epoch;
   int   log_base;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [7:0] mem     [256];
   logic [7:0] wr_data [256];
   int         wr_epoch[256];
   int         wait_cnt;
   int         cyc;
   acc_t       act_q[$];
   int         cyc_q[$];
   acc_t       exp_q[$];

   logic       d0_req, d0_we, d0_halted, d0_illegal;
   logic [7:0] d0_addr, d0_wdata, d0_alu_a, d0_alu_b, d0_res, d0_acc, d0_pc;
   logic [2:0] d0_op;
   logic       d1_req, d1_we, d1_halted, d1_illegal;
   logic [7:0] d1_addr, d1_wdata, d1_alu_a, d1_alu_b, d1_res, d1_acc, d1_pc;
   logic [2:0] d1_op;
   logic       m_req, m_we, m_ack, m_halted, m_illegal;
   logic [7:0] m_addr, m_wdata, m_rdata, m_acc, m_pc;

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      case (op)
         ALU_ADD:   return a + b;
         ALU_SUB:   return a - b;
         ALU_AND:   return a & b;
         ALU_OR:    return a | b;
         ALU_XOR:   return a ^ b;
         ALU_PASSB: return b;
         ALU_SHR:   return a >> 1;
         default:   return ~a;
      endcase
   endfunction

   assign d0_res = alu_f(d0_alu_a, d0_alu_b, d0_op);
   assign d1_res = alu_f(d1_alu_a, d1_alu_b, d1_op);

   minibyte_ctrl dut (
      .clk(clk), .rst(rst0),
      .mem_req(d0_req), .mem_we(d0_we), .mem_addr(d0_addr), .mem_wdata(d0_wdata),
      .mem_rdata(m_rdata), .mem_ack(m_ack & ~sel),
      .alu_a(d0_alu_a), .alu_b(d0_alu_b), .alu_op(d0_op),
      .alu_res(d0_res), .alu_z(d0_res == 8'h00), .alu_n(d0_res[7]),
      .acc_out(d0_acc), .pc_out(d0_pc), .halted(d0_halted), .illegal(d0_illegal)
   );

   minibyte_ctrl #(.RESET_PC(8'hFE)) dut_fe (
      .clk(clk), .rst(rst1),
      .mem_req(d1_req), .mem_we(d1_we), .mem_addr(d1_addr), .mem_wdata(d1_wdata),
      .mem_rdata(m_rdata), .mem_ack(m_ack & sel),
      .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_op(d1_op),
      .alu_res(d1_res), .alu_z(d1_res == 8'h00), .alu_n(d1_res[7]),
      .acc_out(d1_acc), .pc_out(d1_pc), .halted(d1_halted), .illegal(d1_illegal)
   );

   assign m_req     = sel ? d1_req     : d0_req;
   assign m_we      = sel ? d1_we      : d0_we;
   assign m_addr    = sel ? d1_addr    : d0_addr;
   assign m_wdata   = sel ? d1_wdata   : d0_wdata;
   assign m_halted  = sel ? d1_halted  : d0_halted;
   assign m_illegal = sel ? d1_illegal : d0_illegal;
   assign m_acc     = sel ? d1_acc     : d0_acc;
   assign m_pc      = sel ? d1_pc      : d0_pc;

   // ack_lat is the number of mem_ack=0 wait cycles before each access completes.
   assign m_ack   = m_req && (wait_cnt >= ack_lat);
   assign m_rdata = (wr_epoch[m_addr] == epoch) ? wr_data[m_addr] : mem[m_addr];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (m_req && m_ack) begin
         act_q.push_back(acc_t'{m_we, m_addr, (m_we ? m_wdata : m_rdata)});
         cyc_q.push_back(cyc);
         if (m_we) begin
            wr_data[m_addr]  <= m_wdata;
            wr_epoch[m_addr] <= epoch;
         end
         wait_cnt <= 0;
      end else if (m_req) begin
         wait_cnt <= wait_cnt + 1;
      end else begin
         wait_cnt <= 0;
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = OP_HLT;
      epoch++;
   endtask

   task automatic load(input logic [7:0] addr, input logic [7:0] b0, input logic [7:0] b1);
      mem[addr]         = b0;
      mem[addr + 8'd1]  = b1;
   endtask

   task automatic push_exp(input logic we, input logic [7:0] addr, input logic [7:0] data);
      exp_q.push_back(acc_t'{we, addr, data});
   endtask

   task automatic do_reset(input logic s, input int lat);
      rst0    = 1'b1;
      rst1    = 1'b1;
      sel     = s;
      ack_lat = lat;
      repeat (2) @(posedge clk);
      @(negedge clk);
      log_base = act_q.size();
      if (s) rst1 = 1'b0;
      else   rst0 = 1'b0;
   endtask

   task automatic run_until_halt(input int max, output int cycles, output bit ok);
      cycles = 0;
      ok     = 1'b0;
      while (cycles < max && !ok) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if (m_halted) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      bit found = 1'b0;
      clear_mem();
      load(8'h00, OP_LDI, 8'h05);
      do_reset(1'b0, 6);
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (m_req && !m_we && m_addr == 8'h01) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("[TB] FAIL reset_reach_fetch_arg: no fetch @01 within 30 cycles, required one");
      end
      #2 rst0 = 1'b1;
      #1;
      n_checks++;
      if (d0_req !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_req_drop: mem_req=%b required 0", d0_req);
      end
      n_checks++;
      if (d0_we !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_we_drop: mem_we=%b required 0", d0_we);
      end
      @(posedge clk);
      @(negedge clk);
      ack_lat = 0;
      rst0    = 1'b0;
      #1;
      n_checks++;
      if (d0_pc !== 8'h00 || d0_acc !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL reset_regs: pc=%h acc=%h required 00/00", d0_pc, d0_acc);
      end
      n_checks++;
      if (d0_halted !== 1'b0 || d0_illegal !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_status: halted=%b illegal=%b required 0/0", d0_halted, d0_illegal);
      end
      n_checks++;
      if (d0_req !== 1'b1 || d0_we !== 1'b0 || d0_addr !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL reset_first_fetch: req=%b we=%b addr=%h required 1/0/00", d0_req, d0_we, d0_addr);
      end
   endtask

   // Run with opcode 08 (ALU op 0) and 0B (ALU op 3): A must equal ALU(5,3,IR[2:0]).
   task automatic test_alu_program();
      logic [7:0] opcs [2] = '{8'h08, 8'h0B};
      logic [7:0] opc;
      logic [7:0] exp_a;
      int         cycles;
      bit         ok;
      for (int k = 0; k < 2; k++) begin
         opc   = opcs[k];
         exp_a = alu_f(8'h05, 8'h03, opc[2:0]);
         clear_mem();
         load(8'h00, OP_LDI, 8'h05);
         load(8'h02, opc, 8'h03);
         load(8'h04, OP_HLT, 8'h00);
         do_reset(1'b0, 0);
         run_until_halt(40, cycles, ok);
         n_checks++;
         if (!ok || cycles != 8) begin
            n_fail++;
            $display("[TB] FAIL alu_halt_cycle op=%h: halted=%b at cycle %0d required cycle 8", opc, ok, cycles);
         end
         n_checks++;
         if (m_acc !== exp_a) begin
            n_fail++;
            $display("[TB] FAIL alu_result op=%h: acc=%h required %h", opc, m_acc, exp_a);
         end
         n_checks++;
         if (m_pc !== 8'h06 || m_illegal !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL alu_pc op=%h: pc=%h illegal=%b required 06/0", opc, m_pc, m_illegal);
         end
      end
   endtask

   // LDA sets N=1/Z=0, so the JN at 08 is taken and the JZ at 20 falls through.
   task automatic test_sta_lda();
      int   cycles;
      bit   ok;
      acc_t e;
      clear_mem();
      load(8'h00, OP_LDI, 8'hAA);
      load(8'h02, OP_STA, 8'h40);
      load(8'h04, OP_LDI, 8'h00);
      load(8'h06, OP_LDA, 8'h40);
      load(8'h08, OP_JN,  8'h20);
      load(8'h20, OP_JZ,  8'h30);
      load(8'h22, OP_HLT, 8'h00);
      mem[8'h40] = 8'h11;
      push_exp(0, 8'h00, OP_LDI); push_exp(0, 8'h01, 8'hAA);
      push_exp(0, 8'h02, OP_STA); push_exp(0, 8'h03, 8'h40);
      push_exp(1, 8'h40, 8'hAA);
      push_exp(0, 8'h04, OP_LDI); push_exp(0, 8'h05, 8'h00);
      push_exp(0, 8'h06, OP_LDA); push_exp(0, 8'h07, 8'h40);
      push_exp(0, 8'h40, 8'hAA);
      push_exp(0, 8'h08, OP_JN);  push_exp(0, 8'h09, 8'h20);
      push_exp(0, 8'h20, OP_JZ);  push_exp(0, 8'h21, 8'h30);
      push_exp(0, 8'h22, OP_HLT); push_exp(0, 8'h23, 8'h00);
      do_reset(1'b0, 0);
      run_until_halt(100, cycles, ok);
      n_checks++;
      if (act_q.size() - log_base != 16 || !ok) begin
         n_fail++;
         $display("[TB] FAIL sta_lda_count: %0d accesses halted=%b required 16/1", act_q.size() - log_base, ok);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (log_base + i >= act_q.size()) begin
            n_fail++;
            $display("[TB] FAIL sta_lda_access %0d: missing, required we=%b addr=%h data=%h", i, e.we, e.addr, e.data);
         end else if (act_q[log_base + i] !== e) begin
            n_fail++;
            $display("[TB] FAIL sta_lda_access %0d: we=%b addr=%h data=%h required we=%b addr=%h data=%h", i,
                     act_q[log_base + i].we, act_q[log_base + i].addr, act_q[log_base + i].data, e.we, e.addr, e.data);
         end
      end
      if (cyc_q.size() >= log_base + 11) begin
         n_checks++;
         if (cyc_q[log_base + 5] - cyc_q[log_base + 2] != 3) begin
            n_fail++;
            $display("[TB] FAIL sta_latency: %0d cycles required 3", cyc_q[log_base + 5] - cyc_q[log_base + 2]);
         end
         n_checks++;
         if (cyc_q[log_base + 10] - cyc_q[log_base + 7] != 4) begin
            n_fail++;
            $display("[TB] FAIL lda_latency: %0d cycles required 4", cyc_q[log_base + 10] - cyc_q[log_base + 7]);
         end
      end
      n_checks++;
      if (m_acc !== 8'hAA) begin
         n_fail++;
         $display("[TB] FAIL lda_acc: acc=%h required aa", m_acc);
      end
   endtask

   // Scenario 0: JMP at FE to 10. Scenario 1: NOP at FE, PC wraps to 00.
   task automatic test_branch_wrap();
      int   cycles;
      bit   ok;
      acc_t e;
      logic [7:0] exp_pc;
      for (int s = 0; s < 2; s++) begin
         clear_mem();
         if (s == 0) begin
            load(8'hFE, OP_JMP, 8'h10);
            load(8'h10, OP_HLT, 8'h00);
            push_exp(0, 8'hFE, OP_JMP); push_exp(0, 8'hFF, 8'h10);
            push_exp(0, 8'h10, OP_HLT); push_exp(0, 8'h11, 8'h00);
            exp_pc = 8'h12;
         end else begin
            load(8'hFE, OP_NOP, 8'h00);
            load(8'h00, OP_HLT, 8'h00);
            push_exp(0, 8'hFE, OP_NOP); push_exp(0, 8'hFF, 8'h00);
            push_exp(0, 8'h00, OP_HLT); push_exp(0, 8'h01, 8'h00);
            exp_pc = 8'h02;
         end
         do_reset(1'b1, 0);
         #1;
         n_checks++;
         if (m_pc !== 8'hFE) begin
            n_fail++;
            $display("[TB] FAIL branch_reset_pc s%0d: pc=%h required fe", s, m_pc);
         end
         run_until_halt(40, cycles, ok);
         for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (log_base + i >= act_q.size()) begin
               n_fail++;
               $display("[TB] FAIL branch_access s%0d.%0d: missing, required addr=%h data=%h", s, i, e.addr, e.data);
            end else if (act_q[log_base + i] !== e) begin
               n_fail++;
               $display("[TB] FAIL branch_access s%0d.%0d: addr=%h data=%h required addr=%h data=%h", s, i,
                        act_q[log_base + i].addr, act_q[log_base + i].data, e.addr, e.data);
            end
         end
         n_checks++;
         if (!ok || m_pc !== exp_pc) begin
            n_fail++;
            $display("[TB] FAIL branch_final_pc s%0d: halted=%b pc=%h required 1/%h", s, ok, m_pc, exp_pc);
         end
      end
   endtask

   // Memory registers the request, then acks three cycles later: 4 wait cycles per access.
   task automatic test_wait_states();
      int lat = 4;
      int nop_cycles;
      clear_mem();
      load(8'h00, OP_NOP, 8'h00);
      load(8'h02, OP_HLT, 8'h00);
      push_exp(0, 8'h00, OP_NOP); push_exp(0, 8'h01, 8'h00);
      push_exp(0, 8'h02, OP_HLT); push_exp(0, 8'h03, 8'h00);
      do_reset(1'b0, lat);
      for (int c = 0; c < 80 && !m_halted; c++) begin
         if (m_req) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL wait_unexpected_req: addr=%h we=%b required no request", m_addr, m_we);
            end else if (m_addr !== exp_q[0].addr || m_we !== exp_q[0].we) begin
               n_fail++;
               $display("[TB] FAIL wait_stable cycle %0d: addr=%h we=%b required %h/%b", c, m_addr, m_we,
                        exp_q[0].addr, exp_q[0].we);
            end
            if (m_ack && exp_q.size() > 0) void'(exp_q.pop_front());
         end
         @(posedge clk);
         @(negedge clk);
      end
      n_checks++;
      if (!m_halted || exp_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL wait_complete: halted=%b pending=%0d required 1/0", m_halted, exp_q.size());
      end
      exp_q.delete();
      nop_cycles = (cyc_q.size() >= log_base + 3) ? cyc_q[log_base + 2] - cyc_q[log_base] : -1;
      n_checks++;
      if (nop_cycles != 3 + 2 * lat) begin
         n_fail++;
         $display("[TB] FAIL wait_nop_latency: %0d cycles required %0d", nop_cycles, 3 + 2 * lat);
      end
   endtask

   task automatic test_illegal();
      int cycles;
      bit ok;
      int stray = 0;
      clear_mem();
      load(8'h00, 8'h5A, 8'h00);
      do_reset(1'b0, 0);
      run_until_halt(20, cycles, ok);
      n_checks++;
      if (!ok || cycles != 2) begin
         n_fail++;
         $display("[TB] FAIL illegal_halt: halted=%b at cycle %0d required cycle 2", ok, cycles);
      end
      n_checks++;
      if (m_illegal !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL illegal_flag: illegal=%b required 1", m_illegal);
      end
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (m_req !== 1'b0) stray++;
      end
      n_checks++;
      if (stray != 0 || m_halted !== 1'b1 || m_illegal !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL illegal_absorb: %0d request cycles halted=%b illegal=%b required 0/1/1",
                  stray, m_halted, m_illegal);
      end
   endtask

   initial begin
      rst0    = 1'b1;
      rst1    = 1'b1;
      sel     = 1'b0;
      ack_lat = 0;
      epoch   = 1;
      $display("[TB] starting minibyte_ctrl bench");
      test_reset();
      test_alu_program();
      test_sta_lda();
      test_branch_wrap();
      test_wait_states();
      test_illegal();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded 500us, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
